// File: rtl/sv32_tlb_pkg.sv
// Shared Sv32 types and TLB sizing defaults for the ITLB/DTLB instances.
// The index and tag widths below apply to the default sizing only.
package sv32_tlb_pkg;

  localparam int VPN_WIDTH  = 20;
  localparam int VPN1_WIDTH = 10;
  localparam int VPN0_WIDTH = 10;
  localparam int ASID_WIDTH = 9;
  localparam int PPN_WIDTH  = 22;

  localparam int TLB_ENTRIES_4K = 32;
  localparam int TLB_ASSOC_4K   = 2;
  localparam int TLB_ENTRIES_4M = 8;
  localparam int TLB_ASSOC_4M   = 2;

  localparam int TLB_SETS_4K = TLB_ENTRIES_4K / TLB_ASSOC_4K;
  localparam int TLB_SETS_4M = TLB_ENTRIES_4M / TLB_ASSOC_4M;
  localparam int TLB_IDX_4K  = $clog2(TLB_SETS_4K);
  localparam int TLB_IDX_4M  = $clog2(TLB_SETS_4M);
  localparam int TLB_TAG_4K  = VPN_WIDTH - TLB_IDX_4K;
  localparam int TLB_TAG_4M  = VPN1_WIDTH - TLB_IDX_4M;

  typedef struct packed {
    logic [PPN_WIDTH-1:0] ppn;
    logic [1:0]           rsw;
    logic                 d;
    logic                 a;
    logic                 g;
    logic                 u;
    logic                 x;
    logic                 w;
    logic                 r;
    logic                 v;
  } pte_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } tlb_state_e;

endpackage

// File: rtl/sv32_tlb_way_array.sv
// One set-associative TLB array: entry flops, lookup match, fill way choice
// with per-set round-robin replacement, and a per-set invalidate port.
module sv32_tlb_way_array
  import sv32_tlb_pkg::*;
#(
  parameter int NUM_SETS  = 16,
  parameter int ASSOC     = 2,
  parameter int TAG_WIDTH = 16,
  localparam int IDX_W    = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [IDX_W-1:0]      i_lk_idx,
  input  logic [TAG_WIDTH-1:0]  i_lk_tag,
  input  logic [ASID_WIDTH-1:0] i_lk_asid,
  output logic                  o_lk_hit,
  output pte_t                  o_lk_pte,
  input  logic                  i_fill_en,
  input  logic [IDX_W-1:0]      i_fill_idx,
  input  logic [TAG_WIDTH-1:0]  i_fill_tag,
  input  logic [ASID_WIDTH-1:0] i_fill_asid,
  input  pte_t                  i_fill_pte,
  input  logic                  i_inv_en,
  input  logic [IDX_W-1:0]      i_inv_idx,
  input  logic                  i_inv_vpn_en,
  input  logic [TAG_WIDTH-1:0]  i_inv_tag,
  input  logic                  i_inv_asid_en,
  input  logic [ASID_WIDTH-1:0] i_inv_asid
);

  localparam int RR_W = (ASSOC > 1) ? $clog2(ASSOC) : 1;

  logic                  r_valid [NUM_SETS][ASSOC];
  logic [TAG_WIDTH-1:0]  r_tag   [NUM_SETS][ASSOC];
  logic [ASID_WIDTH-1:0] r_asid  [NUM_SETS][ASSOC];
  pte_t                  r_pte   [NUM_SETS][ASSOC];
  logic [RR_W-1:0]       r_rr    [NUM_SETS];

  logic            w_has_match;
  logic [RR_W-1:0] w_match_way;
  logic            w_has_inv;
  logic [RR_W-1:0] w_inv_way;
  logic [RR_W-1:0] w_fill_way;
  logic            w_use_rr;

  always_comb begin
    o_lk_hit = 1'b0;
    o_lk_pte = '0;
    for (int w = 0; w < ASSOC; w++) begin
      if (r_valid[i_lk_idx][w] && (r_tag[i_lk_idx][w] == i_lk_tag) &&
          (r_pte[i_lk_idx][w].g || (r_asid[i_lk_idx][w] == i_lk_asid))) begin
        o_lk_hit = 1'b1;
        o_lk_pte = r_pte[i_lk_idx][w];
      end
    end
  end

  // Descending scan so the lowest-index candidate is the one left standing.
  always_comb begin
    w_has_match = 1'b0;
    w_match_way = '0;
    w_has_inv   = 1'b0;
    w_inv_way   = '0;
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (r_valid[i_fill_idx][w] && (r_tag[i_fill_idx][w] == i_fill_tag) &&
          (r_asid[i_fill_idx][w] == i_fill_asid)) begin
        w_has_match = 1'b1;
        w_match_way = RR_W'(w);
      end
      if (!r_valid[i_fill_idx][w]) begin
        w_has_inv = 1'b1;
        w_inv_way = RR_W'(w);
      end
    end
    w_use_rr   = !w_has_match && !w_has_inv;
    w_fill_way = w_has_match ? w_match_way :
                 w_has_inv   ? w_inv_way   : r_rr[i_fill_idx];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_rr[s] <= '0;
        for (int w = 0; w < ASSOC; w++) begin
          r_valid[s][w] <= 1'b0;
        end
      end
    end else begin
      if (i_fill_en) begin
        r_valid[i_fill_idx][w_fill_way] <= 1'b1;
        r_tag[i_fill_idx][w_fill_way]   <= i_fill_tag;
        r_asid[i_fill_idx][w_fill_way]  <= i_fill_asid;
        r_pte[i_fill_idx][w_fill_way]   <= i_fill_pte;
        if (w_use_rr) begin
          r_rr[i_fill_idx] <= (r_rr[i_fill_idx] == RR_W'(ASSOC - 1)) ? '0
                              : r_rr[i_fill_idx] + RR_W'(1);
        end
      end
      if (i_inv_en) begin
        for (int w = 0; w < ASSOC; w++) begin
          if ((!i_inv_vpn_en || (r_tag[i_inv_idx][w] == i_inv_tag)) &&
              (!i_inv_asid_en || ((r_asid[i_inv_idx][w] == i_inv_asid) &&
                                  !r_pte[i_inv_idx][w].g))) begin
            r_valid[i_inv_idx][w] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/sv32_tlb.sv
// Sv32 TLB top: 4KB and 4MB arrays, registered lookup response, and the
// set-walking SFENCE.VMA flush FSM.
module sv32_tlb
  import sv32_tlb_pkg::*;
#(
  parameter int ENTRIES_4K = TLB_ENTRIES_4K,
  parameter int ASSOC_4K   = TLB_ASSOC_4K,
  parameter int ENTRIES_4M = TLB_ENTRIES_4M,
  parameter int ASSOC_4M   = TLB_ASSOC_4M
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [VPN_WIDTH-1:0]  req_vpn,
  input  logic [ASID_WIDTH-1:0] req_asid,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output pte_t                  resp_pte,
  output logic                  resp_superpage,
  input  logic                  fill_valid,
  output logic                  fill_ready,
  input  logic [VPN_WIDTH-1:0]  fill_vpn,
  input  logic [ASID_WIDTH-1:0] fill_asid,
  input  pte_t                  fill_pte,
  input  logic                  fill_superpage,
  input  logic                  sfence_valid,
  output logic                  sfence_ready,
  input  logic                  sfence_vpn_en,
  input  logic [VPN_WIDTH-1:0]  sfence_vpn,
  input  logic                  sfence_asid_en,
  input  logic [ASID_WIDTH-1:0] sfence_asid,
  output logic                  sfence_done,
  output tlb_state_e            dbg_state
);

  localparam int NUM_SETS_4K = ENTRIES_4K / ASSOC_4K;
  localparam int NUM_SETS_4M = ENTRIES_4M / ASSOC_4M;
  localparam int IDX4K       = $clog2(NUM_SETS_4K);
  localparam int IDX4M       = $clog2(NUM_SETS_4M);
  localparam int TAG4K       = VPN_WIDTH - IDX4K;
  localparam int TAG4M       = VPN1_WIDTH - IDX4M;
  localparam int FLUSH_SETS  = (NUM_SETS_4K > NUM_SETS_4M) ? NUM_SETS_4K : NUM_SETS_4M;
  localparam int CNT_W       = (FLUSH_SETS > 1) ? $clog2(FLUSH_SETS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_SETS - 1);
  localparam bit DONE_ON_ENTRY = (FLUSH_SETS == 1);

  tlb_state_e            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_sf_vpn_en;
  logic [VPN_WIDTH-1:0]  r_sf_vpn;
  logic                  r_sf_asid_en;
  logic [ASID_WIDTH-1:0] r_sf_asid;

  logic w_req_acc;
  logic w_fill_acc;
  logic w_hit4k;
  logic w_hit4m;
  pte_t w_pte4k;
  pte_t w_pte4m;
  logic w_inv4k;
  logic w_inv4m;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid is never qualified by ready, and a dropped fill is simply lost.
  assign req_ready    = (r_state == ST_IDLE);
  assign sfence_ready = (r_state == ST_IDLE);
  assign fill_ready   = (r_state == ST_IDLE) && !sfence_valid;
  assign dbg_state    = r_state;
  assign w_req_acc    = req_valid && req_ready;
  assign w_fill_acc   = fill_valid && fill_ready;

  // A vpn-specific flush only touches the set the address indexes.
  assign w_inv4k = (r_state == ST_FLUSH) && (int'(r_cnt) < NUM_SETS_4K) &&
                   (!r_sf_vpn_en || (r_sf_vpn[IDX4K-1:0] == r_cnt[IDX4K-1:0]));
  assign w_inv4m = (r_state == ST_FLUSH) && (int'(r_cnt) < NUM_SETS_4M) &&
                   (!r_sf_vpn_en ||
                    (r_sf_vpn[VPN0_WIDTH +: IDX4M] == r_cnt[IDX4M-1:0]));

  sv32_tlb_way_array #(
    .NUM_SETS (NUM_SETS_4K),
    .ASSOC    (ASSOC_4K),
    .TAG_WIDTH(TAG4K)
  ) u_arr_4k (
    .i_clk        (CLK),
    .i_rst_n      (nRST),
    .i_lk_idx     (req_vpn[IDX4K-1:0]),
    .i_lk_tag     (req_vpn[VPN_WIDTH-1:IDX4K]),
    .i_lk_asid    (req_asid),
    .o_lk_hit     (w_hit4k),
    .o_lk_pte     (w_pte4k),
    .i_fill_en    (w_fill_acc && !fill_superpage),
    .i_fill_idx   (fill_vpn[IDX4K-1:0]),
    .i_fill_tag   (fill_vpn[VPN_WIDTH-1:IDX4K]),
    .i_fill_asid  (fill_asid),
    .i_fill_pte   (fill_pte),
    .i_inv_en     (w_inv4k),
    .i_inv_idx    (r_cnt[IDX4K-1:0]),
    .i_inv_vpn_en (r_sf_vpn_en),
    .i_inv_tag    (r_sf_vpn[VPN_WIDTH-1:IDX4K]),
    .i_inv_asid_en(r_sf_asid_en),
    .i_inv_asid   (r_sf_asid)
  );

  sv32_tlb_way_array #(
    .NUM_SETS (NUM_SETS_4M),
    .ASSOC    (ASSOC_4M),
    .TAG_WIDTH(TAG4M)
  ) u_arr_4m (
    .i_clk        (CLK),
    .i_rst_n      (nRST),
    .i_lk_idx     (req_vpn[VPN0_WIDTH +: IDX4M]),
    .i_lk_tag     (req_vpn[VPN_WIDTH-1:VPN0_WIDTH+IDX4M]),
    .i_lk_asid    (req_asid),
    .o_lk_hit     (w_hit4m),
    .o_lk_pte     (w_pte4m),
    .i_fill_en    (w_fill_acc && fill_superpage),
    .i_fill_idx   (fill_vpn[VPN0_WIDTH +: IDX4M]),
    .i_fill_tag   (fill_vpn[VPN_WIDTH-1:VPN0_WIDTH+IDX4M]),
    .i_fill_asid  (fill_asid),
    .i_fill_pte   (fill_pte),
    .i_inv_en     (w_inv4m),
    .i_inv_idx    (r_cnt[IDX4M-1:0]),
    .i_inv_vpn_en (r_sf_vpn_en),
    .i_inv_tag    (r_sf_vpn[VPN_WIDTH-1:VPN0_WIDTH+IDX4M]),
    .i_inv_asid_en(r_sf_asid_en),
    .i_inv_asid   (r_sf_asid)
  );

  // sfence_done is registered one cycle early so it lands on the last FLUSH cycle.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_sf_vpn_en    <= 1'b0;
      r_sf_vpn       <= '0;
      r_sf_asid_en   <= 1'b0;
      r_sf_asid      <= '0;
      resp_valid     <= 1'b0;
      resp_hit       <= 1'b0;
      resp_pte       <= '0;
      resp_superpage <= 1'b0;
      sfence_done    <= 1'b0;
    end else begin
      resp_valid  <= w_req_acc;
      sfence_done <= 1'b0;
      if (w_req_acc) begin
        resp_hit       <= w_hit4k || w_hit4m;
        resp_pte       <= w_hit4k ? w_pte4k : w_pte4m;
        resp_superpage <= !w_hit4k && w_hit4m;
      end
      case (r_state)
        ST_IDLE: begin
          if (sfence_valid) begin
            r_state      <= ST_FLUSH;
            r_cnt        <= '0;
            r_sf_vpn_en  <= sfence_vpn_en;
            r_sf_vpn     <= sfence_vpn;
            r_sf_asid_en <= sfence_asid_en;
            r_sf_asid    <= sfence_asid;
            sfence_done  <= DONE_ON_ENTRY;
          end
        end
        ST_FLUSH: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt       <= r_cnt + CNT_W'(1);
            sfence_done <= ((r_cnt + CNT_W'(1)) == CNT_LAST);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
